// File: rtl/rip_bp_inflight_queue_if.sv
// Branch-predictor in-flight queue channel bundle.
// Carries three groups of signals:
//   - fetch push:         push_valid/ready, push_pc, push_index, push_weight, push_pred
//   - execute resolve:    resolve_valid, resolve_pc, resolve_taken
//   - predictor update:   update, update_index, update_weight, actual, mispredict
// Modports:
//   - master: the pipeline side, which drives push/resolve and observes updates.
//   - slave:  the queue itself.
interface rip_bp_inflight_queue_if #(
  parameter int INDEX_WIDTH  = 10,
  parameter int WEIGHT_WIDTH = 2
);
  logic                    push_valid;
  logic                    push_ready;
  logic [31:0]             push_pc;
  logic [INDEX_WIDTH-1:0]  push_index;
  logic [WEIGHT_WIDTH-1:0] push_weight;
  logic                    push_pred;

  logic                    resolve_valid;
  logic [31:0]             resolve_pc;
  logic                    resolve_taken;

  logic                    update;
  logic [INDEX_WIDTH-1:0]  update_index;
  logic [WEIGHT_WIDTH-1:0] update_weight;
  logic                    actual;
  logic                    mispredict;

  modport master (
    output push_valid, push_pc, push_index, push_weight, push_pred,
    output resolve_valid, resolve_pc, resolve_taken,
    input  push_ready, update, update_index, update_weight, actual, mispredict
  );

  modport slave (
    input  push_valid, push_pc, push_index, push_weight, push_pred,
    input  resolve_valid, resolve_pc, resolve_taken,
    output push_ready, update, update_index, update_weight, actual, mispredict
  );
endinterface

// File: rtl/rip_bp_inflight_queue.sv
// In-order queue of conditional branches between fetch and execute.
//
// Fetch pushes the predictor lookup result for each branch. When execute
// resolves the oldest branch, the entry is popped. One cycle later the block
// drives the predictor update port.
//
// On a direction mispredict, every younger entry is squashed.
//
// Ports:
//   clk, rstn  clock; synchronous active-low reset
//   stall      freezes pointers, count and storage; push and resolve are ignored
//   flush      empties the queue; push and resolve are dropped
//   bp         push / resolve / update channel (slave side)
//   count      current occupancy
//   err        sticky protocol error:
//                - resolve while empty
//                - resolve PC does not match the head entry's PC
module rip_bp_inflight_queue #(
  parameter int DEPTH        = 8,
  parameter int INDEX_WIDTH  = 10,
  parameter int WEIGHT_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     stall,
  input  logic                     flush,
  rip_bp_inflight_queue_if.slave   bp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;

  typedef struct packed {
    logic [31:0]             pc;
    logic [INDEX_WIDTH-1:0]  index;
    logic [WEIGHT_WIDTH-1:0] weight;
    logic                    pred;
  } entry_t;

  entry_t mem [DEPTH];
  ptr_t   head, tail;

  logic   full, empty, run;
  logic   do_pop, do_push, mis;
  entry_t head_e;

  // NOTE: every signal driven here gets a value on every path; a missing
  // default would infer a latch.
  always_comb begin
    full          = (count == CW'(DEPTH));
    empty         = (count == '0);
    run           = rstn && !flush && !stall;
    head_e        = mem[head];
    // While in reset, push_ready is forced to 1; nothing is accepted until
    // reset is released, because run is low.
    bp.push_ready = !rstn || (!full && !stall && !flush);
    do_pop        = run && bp.resolve_valid && !empty;
    mis           = do_pop && (bp.resolve_taken != head_e.pred);
    // A push that coincides with a mispredict came from the wrong path.
    do_push       = run && bp.push_valid && !full && !mis;
  end

  // NOTE: entry storage has no reset. Entries are only read once count
  // marks them valid, so clearing the array would add logic for nothing.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail] <= '{pc:     bp.push_pc,
                     index:  bp.push_index,
                     weight: bp.push_weight,
                     pred:   bp.push_pred};
    end
  end

  // NOTE: state registers use non-blocking assignments only. Every flop then
  // samples pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      err              <= 1'b0;
      bp.update        <= 1'b0;
      bp.mispredict    <= 1'b0;
      bp.update_index  <= '0;
      bp.update_weight <= '0;
      bp.actual        <= 1'b0;
    end else begin
      bp.update     <= do_pop;
      bp.mispredict <= mis;

      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else if (!stall) begin
        if (bp.resolve_valid && empty) err <= 1'b1;

        if (do_pop) begin
          head             <= head + ptr_t'(1);
          bp.update_index  <= head_e.index;
          bp.update_weight <= head_e.weight;
          bp.actual        <= bp.resolve_taken;
          if (bp.resolve_pc != head_e.pc) err <= 1'b1;
        end

        if (mis) begin
          // Squash: the new tail meets the new head, so the queue is empty.
          tail  <= head + ptr_t'(1);
          count <= '0;
        end else begin
          if (do_push) tail <= tail + ptr_t'(1);
          case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_rip_bp_inflight_queue.sv
module tb_rip_bp_inflight_queue;

  localparam int DEPTH = 8;
  localparam int IW    = 10;
  localparam int WW    = 2;

  logic       clk = 1'b0;
  logic       rstn, stall, flush;
  logic [3:0] count;
  logic       err;

  rip_bp_inflight_queue_if #(.INDEX_WIDTH(IW), .WEIGHT_WIDTH(WW)) bp_if ();

  rip_bp_inflight_queue #(
    .DEPTH       (DEPTH),
    .INDEX_WIDTH (IW),
    .WEIGHT_WIDTH(WW)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .stall(stall),
    .flush(flush),
    .bp   (bp_if),
    .count(count),
    .err  (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a plain queue of branches ----------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] idx;
    logic [31:0] wt;
    logic        pred;
  } br_t;

  br_t         q[$];
  logic        m_err, m_upd, m_mis, m_act;
  logic [31:0] m_idx, m_wt;
  bit          model_live = 0;

  always @(posedge clk) begin
    bit  room;
    br_t e;
    model_live = 1;
    if (!rstn) begin
      q.delete();
      m_err = 0;
      m_upd = 0;
      m_mis = 0;
      m_idx = 0;
      m_wt  = 0;
      m_act = 0;
    end else begin
      m_upd = 0;
      m_mis = 0;
      if (flush) begin
        q.delete();
      end else if (!stall) begin
        room = (q.size() < DEPTH);
        if (bp_if.resolve_valid) begin
          if (q.size() == 0) begin
            m_err = 1;
          end else begin
            e     = q.pop_front();
            m_upd = 1;
            m_idx = e.idx;
            m_wt  = e.wt;
            m_act = bp_if.resolve_taken;
            if (bp_if.resolve_pc != e.pc) m_err = 1;
            if (bp_if.resolve_taken != e.pred) begin
              m_mis = 1;
              q.delete();
            end
          end
        end
        if (bp_if.push_valid && room && !m_mis) begin
          q.push_back('{pc:   bp_if.push_pc,
                        idx:  32'(bp_if.push_index),
                        wt:   32'(bp_if.push_weight),
                        pred: bp_if.push_pred});
        end
      end
    end
  end

  // Compare every cycle, on the falling edge.
  always @(negedge clk) begin
    if (model_live) begin
      check("update",     32'(bp_if.update),        32'(m_upd));
      check("mispredict", 32'(bp_if.mispredict),    32'(m_mis));
      check("upd_index",  32'(bp_if.update_index),  m_idx);
      check("upd_weight", 32'(bp_if.update_weight), m_wt);
      check("actual",     32'(bp_if.actual),        32'(m_act));
      check("count",      32'(count),               32'(q.size()));
      check("err",        32'(err),                 32'(m_err));
      check("push_ready", 32'(bp_if.push_ready),
            32'(!rstn || (q.size() < DEPTH && !stall && !flush)));
    end
  end

  // ---------------- stimulus ----------------
  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bp_if.push_valid    = 0;
    bp_if.resolve_valid = 0;
  endtask

  task automatic set_push(input logic [31:0] pc, input int idx, input int wt, input logic pred);
    bp_if.push_valid  = 1;
    bp_if.push_pc     = pc;
    bp_if.push_index  = IW'(idx);
    bp_if.push_weight = WW'(wt);
    bp_if.push_pred   = pred;
  endtask

  task automatic set_res(input logic [31:0] pc, input logic taken);
    bp_if.resolve_valid = 1;
    bp_if.resolve_pc    = pc;
    bp_if.resolve_taken = taken;
  endtask

  task automatic push(input logic [31:0] pc, input int idx, input int wt, input logic pred);
    set_push(pc, idx, wt, pred);
    step();
    idle();
  endtask

  task automatic resolve(input logic [31:0] pc, input logic taken);
    set_res(pc, taken);
    step();
    idle();
  endtask

  initial begin
    rstn                = 0;
    stall               = 0;
    flush               = 1;
    bp_if.push_valid    = 0;
    bp_if.push_pc       = 0;
    bp_if.push_index    = 0;
    bp_if.push_weight   = 0;
    bp_if.push_pred     = 0;
    bp_if.resolve_valid = 0;
    bp_if.resolve_pc    = 0;
    bp_if.resolve_taken = 0;
    step();
    step();

    // Reset state.
    check("rst_count", 32'(count),            0);
    check("rst_ready", 32'(bp_if.push_ready), 1);
    check("rst_err",   32'(err),              0);
    check("rst_upd",   32'(bp_if.update),     0);
    flush = 0;
    rstn  = 1;
    step();

    // Three pushes, then the first resolve.
    push(32'h100, 5, 2, 1);
    push(32'h104, 6, 3, 1);
    push(32'h108, 7, 1, 0);
    check("three_count", 32'(count), 3);
    resolve(32'h100, 1);
    check("r1_update", 32'(bp_if.update),        1);
    check("r1_index",  32'(bp_if.update_index),  5);
    check("r1_weight", 32'(bp_if.update_weight), 2);
    check("r1_actual", 32'(bp_if.actual),        1);
    check("r1_mis",    32'(bp_if.mispredict),    0);
    check("r1_count",  32'(count),               2);
    resolve(32'h104, 1);
    resolve(32'h108, 0);
    step();
    check("r1_hold_index", 32'(bp_if.update_index), 7);

    // Fill to DEPTH.
    for (int i = 0; i < DEPTH; i++) push(32'h200 + 32'(4 * i), i, i % 4, 1);
    check("full_ready", 32'(bp_if.push_ready), 0);
    push(32'h2ff, 99, 0, 1);
    check("full_9th", 32'(count), 8);
    set_res(32'h200, 1);
    set_push(32'h2f0, 1, 1, 1);
    step();
    idle();
    check("full_rp_count", 32'(count), 7);
    for (int i = 1; i < DEPTH; i++) resolve(32'h200 + 32'(4 * i), 1);

    // Mispredict squash.
    for (int i = 0; i < 4; i++) push(32'h300 + 32'(4 * i), 16 + i, 3, 1);
    set_res(32'h300, 0);
    set_push(32'h3f0, 2, 2, 1);
    step();
    idle();
    check("mis_flag",   32'(bp_if.mispredict),   1);
    check("mis_update", 32'(bp_if.update),       1);
    check("mis_actual", 32'(bp_if.actual),       0);
    check("mis_index",  32'(bp_if.update_index), 16);
    check("mis_count",  32'(count),              0);
    step();
    check("mis_pulse",  32'(bp_if.mispredict),   0);

    // Stall.
    push(32'h400, 40, 1, 0);
    push(32'h404, 41, 2, 0);
    stall = 1;
    resolve(32'h400, 0);
    check("stall_upd",   32'(bp_if.update), 0);
    check("stall_count", 32'(count),        2);
    stall = 0;
    resolve(32'h400, 0);
    check("unstall_upd", 32'(bp_if.update),       1);
    check("unstall_idx", 32'(bp_if.update_index), 40);
    resolve(32'h404, 0);

    // Flush with a resolve.
    for (int i = 0; i < 5; i++) push(32'h500 + 32'(4 * i), i, 0, 1);
    flush = 1;
    set_res(32'h500, 1);
    step();
    idle();
    flush = 0;
    check("flush_count", 32'(count),        0);
    check("flush_upd",   32'(bp_if.update), 0);
    check("flush_err",   32'(err),          0);

    // Protocol errors.
    resolve(32'h600, 1);
    check("empty_err", 32'(err),          1);
    check("empty_upd", 32'(bp_if.update), 0);
    push(32'h604, 60, 1, 1);
    resolve(32'h6aa, 1);
    check("badpc_upd", 32'(bp_if.update), 1);
    check("badpc_err", 32'(err),          1);
    set_res(32'h700, 1);
    set_push(32'h700, 70, 3, 1);
    step();
    idle();
    check("empty_push_count", 32'(count), 1);
    push(32'h704, 71, 0, 0);

    // Reset mid-stream.
    rstn = 0;
    step();
    check("rst2_err",   32'(err),              0);
    check("rst2_count", 32'(count),            0);
    check("rst2_ready", 32'(bp_if.push_ready), 1);
    rstn = 1;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rip_bp_inflight_queue.md
Name: rip_bp_inflight_queue

Overview:
- Tracks every conditional branch between fetch and resolution in execute.
- Fetch pushes the predictor's lookup result into an in-order FIFO: table index, counter/weight snapshot, predicted direction and PC.
- When execute resolves the oldest branch, the block pops the entry and drives the predictor update port (update, update_index, update_weight, actual) one cycle later.
- On a direction mispredict it flags the mispredict and discards all younger in-flight entries.

Parameters:
- DEPTH, 8, number of in-flight branch entries; power of two, at least 2.
- INDEX_WIDTH, 10, width of the predictor table index.
- WEIGHT_WIDTH, 2, width of the predictor weight/counter snapshot.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- stall  in  1  pipeline stall; freezes the queue
- flush  in  1  external flush (trap/redirect); empties the queue
- push_valid  in  1  fetch presents a predicted branch
- push_ready  out  1  queue can accept a push
- push_pc  in  32  branch PC
- push_index  in  INDEX_WIDTH  predictor table index used for this branch
- push_weight  in  WEIGHT_WIDTH  predictor weight read for this branch
- push_pred  in  1  predicted direction (1 = taken)
- resolve_valid  in  1  execute resolves the oldest branch
- resolve_pc  in  32  PC of the resolved branch
- resolve_taken  in  1  actual direction
- update  out  1  predictor update strobe
- update_index  out  INDEX_WIDTH  index to update
- update_weight  out  WEIGHT_WIDTH  weight snapshot to update from
- actual  out  1  actual direction for the update
- mispredict  out  1  pulse: resolved direction differs from the prediction
- count  out  $clog2(DEPTH)+1  current occupancy
- err  out  1  sticky protocol error

Behaviour:
- Reset: rstn is synchronous and active-low, sampled on posedge clk. While low, every output is 0, except push_ready = 1.
  - Head/tail pointers are 0, count is 0 and err is cleared.
  - Entry storage is not reset.
- Storage: circular buffer with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. count is held as a separate register.
  - full = (count == DEPTH); empty = (count == 0).
- push_ready = !full && !stall && !flush. It is combinational from registered state and inputs; there is no pop-to-push bypass.
- Priority per cycle: rstn > flush > stall > normal operation.
- flush = 1:
  - head = tail = 0 and count = 0 next cycle.
  - Any push or resolve in the same cycle is dropped.
  - update and mispredict are 0 next cycle.
- stall = 1 (flush = 0):
  - Pointers, count and storage are held.
  - push and resolve are ignored.
  - update and mispredict are 0 next cycle.
- Normal push: push_valid && push_ready writes {pc, index, weight, pred} at tail, increments tail and increments count.
- Normal resolve: resolve_valid && !empty pops head, increments head and decrements count.
  - Next cycle, registered: update = 1, update_index and update_weight from the entry, actual = resolve_taken.
  - Next cycle, registered: mispredict = (resolve_taken != entry.pred).
  - Latency from resolve to update is exactly 1 cycle. update and mispredict are single-cycle pulses.
- Mispredict squash: when a resolve mispredicts, all entries younger than the popped head are discarded in the same cycle.
  - tail = head + 1 and count = 0.
  - A push in that same cycle is dropped; fetch was on the wrong path.
- Push and resolve in the same cycle without mispredict: both take effect and count is unchanged.
  - When full, push_ready is still 0 in that cycle, because there is no bypass.
- Resolve while empty: no pop and no update; err is set.
  - This applies even if a push occurs in the same cycle; that push is still accepted.
- PC check: a resolve whose resolve_pc != head.pc sets err. The pop and update proceed anyway.
- err is sticky until reset.
- update_index, update_weight and actual hold their last values when update = 0.

Test Plan:
- Reset, then push 3 branches (pc 0x100/0x104/0x108, index 5/6/7, weight 2/3/1, pred 1/1/0); count = 3.
  - Resolve 0x100 taken -> next cycle update = 1, update_index = 5, update_weight = 2, actual = 1, mispredict = 0, count = 2.
- Fill to DEPTH = 8 -> push_ready = 0, and a 9th push is ignored.
  - Resolve plus push in the same cycle -> push rejected, count = 7.
- Queue holds 4 entries, head pred = 1; resolve not-taken -> mispredict = 1 and update = 1 with actual = 0 next cycle.
  - count = 0 next cycle; a simultaneous push is dropped.
- Queue holds 2 entries; assert stall with resolve_valid -> no update, count stays 2.
  - Release stall and resolve -> update follows 1 cycle later.
- Queue holds 5 entries; flush together with resolve_valid -> count = 0 next cycle, update = 0, err stays 0.
- Empty queue, resolve_valid -> err = 1 and update = 0.
  - Push 1 entry, then resolve with a wrong pc -> update still asserted, err remains 1.
  - Assert rstn = 0 mid-stream -> err = 0, count = 0, push_ready = 1.
